// File: rtl/fft8_bin_streamer_if.sv
// Bundle of all signals between FFT8, the bin streamer and its consumers.
// The slave modport is the streamer. The master modport is the side that supplies the bins and takes the stream.
interface fft8_bin_streamer_if #(
    parameter int W = 16
);
    logic                frame_stb;
    logic signed [W-1:0] X0;
    logic signed [W-1:0] X1;
    logic signed [W-1:0] X2;
    logic signed [W-1:0] X3;
    logic signed [W-1:0] X4;
    logic signed [W-1:0] X5;
    logic signed [W-1:0] X6;
    logic signed [W-1:0] X7;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_bin;
    logic [W-1:0]        out_mag;
    logic                out_last;
    logic                peak_valid;
    logic [2:0]          peak_bin;
    logic [W-1:0]        peak_mag;
    logic                overrun;

    modport slave (
        input  frame_stb, X0, X1, X2, X3, X4, X5, X6, X7, out_ready,
        output out_valid, out_bin, out_mag, out_last,
        output peak_valid, peak_bin, peak_mag, overrun
    );

    modport master (
        output frame_stb, X0, X1, X2, X3, X4, X5, X6, X7, out_ready,
        input  out_valid, out_bin, out_mag, out_last,
        input  peak_valid, peak_bin, peak_mag, overrun
    );
endinterface

// File: rtl/fft8_bin_streamer.sv
// Captures one FFT8 frame and streams the bin magnitudes out one beat at a time.
// Reports the largest-magnitude bin of each frame once the frame has completed.
module fft8_bin_streamer #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft8_bin_streamer_if.slave    bus
);
    typedef enum logic [0:0] {IDLE, STREAM} state_t;

    // Saturating absolute value: the most negative code has no positive twin.
    function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] x);
        logic [W-1:0] r;
        if (!x[W-1])
            r = x;
        else if (x == {1'b1, {(W-1){1'b0}}})
            r = {1'b0, {(W-1){1'b1}}};
        else
            r = -x;
        return r;
    endfunction

    state_t              state_reg;
    logic signed [W-1:0] bin_reg [8];
    logic [W-1:0]        max_mag_reg;
    logic [2:0]          max_bin_reg;
    logic                out_valid_reg;
    logic [2:0]          out_bin_reg;
    logic [W-1:0]        out_mag_reg;
    logic                out_last_reg;
    logic                peak_valid_reg;
    logic [2:0]          peak_bin_reg;
    logic [W-1:0]        peak_mag_reg;
    logic                overrun_reg;

    logic signed [W-1:0] x_in [8];
    logic [W-1:0]        mag_of [8];
    logic [W-1:0]        x0_mag;

    logic                xfer;
    logic                beat_gt;
    logic [W-1:0]        max_mag_next;
    logic [2:0]          max_bin_next;
    logic [2:0]          bin_next;

    assign x_in[0] = bus.X0;
    assign x_in[1] = bus.X1;
    assign x_in[2] = bus.X2;
    assign x_in[3] = bus.X3;
    assign x_in[4] = bus.X4;
    assign x_in[5] = bus.X5;
    assign x_in[6] = bus.X6;
    assign x_in[7] = bus.X7;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mag
            assign mag_of[gi] = abs_sat(bin_reg[gi]);
        end
    endgenerate

    // Bin 0 of a freshly captured frame goes straight out, so take its magnitude from the input.
    assign x0_mag = abs_sat(x_in[0]);

    always_comb begin
        xfer         = out_valid_reg & bus.out_ready;
        beat_gt      = out_mag_reg > max_mag_reg;
        max_mag_next = beat_gt ? out_mag_reg : max_mag_reg;
        max_bin_next = beat_gt ? out_bin_reg : max_bin_reg;
        bin_next     = out_bin_reg + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            for (int i = 0; i < 8; i++)
                bin_reg[i] <= '0;
            max_mag_reg    <= '0;
            max_bin_reg    <= '0;
            out_valid_reg  <= 1'b0;
            out_bin_reg    <= '0;
            out_mag_reg    <= '0;
            out_last_reg   <= 1'b0;
            peak_valid_reg <= 1'b0;
            peak_bin_reg   <= '0;
            peak_mag_reg   <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            peak_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.frame_stb) begin
                        for (int i = 0; i < 8; i++)
                            bin_reg[i] <= x_in[i];
                        max_mag_reg   <= '0;
                        max_bin_reg   <= '0;
                        out_valid_reg <= 1'b1;
                        out_bin_reg   <= '0;
                        out_mag_reg   <= x0_mag;
                        out_last_reg  <= 1'b0;
                        state_reg     <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer && out_last_reg) begin
                        peak_valid_reg <= 1'b1;
                        peak_bin_reg   <= max_bin_next;
                        peak_mag_reg   <= max_mag_next;
                        out_bin_reg    <= '0;
                        out_last_reg   <= 1'b0;
                        if (bus.frame_stb) begin
                            // A frame arriving with the final beat is taken without a bubble.
                            for (int i = 0; i < 8; i++)
                                bin_reg[i] <= x_in[i];
                            max_mag_reg <= '0;
                            max_bin_reg <= '0;
                            out_mag_reg <= x0_mag;
                        end else begin
                            max_mag_reg   <= max_mag_next;
                            max_bin_reg   <= max_bin_next;
                            out_valid_reg <= 1'b0;
                            out_mag_reg   <= '0;
                            state_reg     <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            max_mag_reg  <= max_mag_next;
                            max_bin_reg  <= max_bin_next;
                            out_bin_reg  <= bin_next;
                            out_mag_reg  <= mag_of[bin_next];
                            out_last_reg <= (bin_next == 3'd7);
                        end
                        if (bus.frame_stb)
                            overrun_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_bin    = out_bin_reg;
    assign bus.out_mag    = out_mag_reg;
    assign bus.out_last   = out_last_reg;
    assign bus.peak_valid = peak_valid_reg;
    assign bus.peak_bin   = peak_bin_reg;
    assign bus.peak_mag   = peak_mag_reg;
    assign bus.overrun    = overrun_reg;
endmodule

// File: tb/tb_fft8_bin_streamer.sv
// Directed bench for fft8_bin_streamer.
// Each scenario task drives one frame pattern and checks the stream and peak results against hand-computed values.
module tb_fft8_bin_streamer;
    logic clk;
    logic rst_n;
    logic signed [15:0] xv [8];
    int vectors;
    int errors;

    fft8_bin_streamer_if #(.W(16)) bus ();

    assign bus.X0 = xv[0];
    assign bus.X1 = xv[1];
    assign bus.X2 = xv[2];
    assign bus.X3 = xv[3];
    assign bus.X4 = xv[4];
    assign bus.X5 = xv[5];
    assign bus.X6 = xv[6];
    assign bus.X7 = xv[7];

    fft8_bin_streamer #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.frame_stb = c[0] ? 1'b0 : 1'b1;
            tick();
        end
        bus.frame_stb = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_bin !== 3'd0 || bus.out_mag !== 16'd0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_stream: valid=%b bin=%0d mag=%0d last=%b, required all 0",
                     bus.out_valid, bus.out_bin, bus.out_mag, bus.out_last);
        end
        vectors++;
        if (bus.peak_valid !== 1'b0 || bus.peak_bin !== 3'd0 || bus.peak_mag !== 16'd0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_peak: pv=%b pbin=%0d pmag=%0d ovr=%b, required all 0",
                     bus.peak_valid, bus.peak_bin, bus.peak_mag, bus.overrun);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: out_valid=%b required 0", bus.out_valid);
        end
        $display("reset: done");
    endtask

    task automatic test_basic();
        int em [8];
        em = '{0, 2048, 0, 0, 0, 0, 0, 2048};
        xv = '{16'sd0, 16'sd2048, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd2048};
        bus.out_ready = 1'b1;
        bus.frame_stb = 1'b1;
        tick();
        bus.frame_stb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_bin !== 3'(k) || bus.out_mag !== 16'(em[k])
                || bus.out_last !== (k == 7) || bus.peak_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_beat%0d: valid=%b bin=%0d mag=%0d last=%b pv=%b, required 1/%0d/%0d/%0d/0",
                         k, bus.out_valid, bus.out_bin, bus.out_mag, bus.out_last, bus.peak_valid, k, em[k], k == 7);
            end
            tick();
        end
        vectors++;
        if (bus.peak_valid !== 1'b1 || bus.peak_bin !== 3'd1 || bus.peak_mag !== 16'd2048 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_peak: pv=%b pbin=%0d pmag=%0d ov=%b, required 1/1/2048/0",
                     bus.peak_valid, bus.peak_bin, bus.peak_mag, bus.out_valid);
        end
        tick();
        vectors++;
        if (bus.peak_valid !== 1'b0 || bus.peak_bin !== 3'd1 || bus.peak_mag !== 16'd2048) begin
            errors++;
            $display("FAIL basic_peak_hold: pv=%b pbin=%0d pmag=%0d, required 0/1/2048",
                     bus.peak_valid, bus.peak_bin, bus.peak_mag);
        end
        $display("basic: frame streamed, peak bin=%0d mag=%0d", bus.peak_bin, bus.peak_mag);
    endtask

    task automatic test_negative();
        int em [8];
        em = '{5, 32767, 7, 0, 0, 0, 0, 100};
        xv = '{-16'sd5, 16'sh8000, 16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd100};
        bus.out_ready = 1'b1;
        bus.frame_stb = 1'b1;
        tick();
        bus.frame_stb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_bin !== 3'(k) || bus.out_mag !== 16'(em[k])) begin
                errors++;
                $display("FAIL neg_beat%0d: valid=%b bin=%0d mag=%0d, required 1/%0d/%0d",
                         k, bus.out_valid, bus.out_bin, bus.out_mag, k, em[k]);
            end
            tick();
        end
        vectors++;
        if (bus.peak_valid !== 1'b1 || bus.peak_bin !== 3'd1 || bus.peak_mag !== 16'd32767) begin
            errors++;
            $display("FAIL neg_peak: pv=%b pbin=%0d pmag=%0d, required 1/1/32767",
                     bus.peak_valid, bus.peak_bin, bus.peak_mag);
        end
        tick();
        $display("negative: frame streamed, peak bin=%0d mag=%0d", bus.peak_bin, bus.peak_mag);
    endtask

    task automatic test_backpressure();
        int em [8];
        int transfers;
        int overruns;
        logic stb_prev;
        logic rdy;
        em = '{0, 2048, 0, 0, 0, 0, 0, 2048};
        xv = '{16'sd0, 16'sd2048, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd2048};
        transfers = 0;
        overruns = 0;
        stb_prev = 1'b0;
        bus.out_ready = 1'b0;
        bus.frame_stb = 1'b1;
        tick();
        bus.frame_stb = 1'b0;
        // A replacement frame offered mid-stream must not disturb the captured data.
        xv = '{16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000};
        for (int c = 0; c < 40 && transfers < 8; c++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_bin !== 3'(transfers) || bus.out_mag !== 16'(em[transfers])
                || bus.overrun !== stb_prev) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b bin=%0d mag=%0d ovr=%b, required 1/%0d/%0d/%b",
                         c, bus.out_valid, bus.out_bin, bus.out_mag, bus.overrun, transfers, em[transfers], stb_prev);
            end
            if (bus.overrun === 1'b1)
                overruns++;
            rdy = c[0];
            bus.out_ready = rdy;
            bus.frame_stb = (transfers == 3 && !rdy && overruns == 0 && !stb_prev);
            stb_prev = bus.frame_stb;
            tick();
            bus.frame_stb = 1'b0;
            if (rdy)
                transfers++;
        end
        vectors++;
        if (transfers != 8 || overruns != 1) begin
            errors++;
            $display("FAIL bp_counts: transfers=%0d overruns=%0d, required 8/1", transfers, overruns);
        end
        vectors++;
        if (bus.peak_valid !== 1'b1 || bus.peak_bin !== 3'd1 || bus.peak_mag !== 16'd2048 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_peak: pv=%b pbin=%0d pmag=%0d ov=%b, required 1/1/2048/0",
                     bus.peak_valid, bus.peak_bin, bus.peak_mag, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        tick();
        $display("backpressure: %0d transfers, %0d overrun pulses", transfers, overruns);
    endtask

    task automatic test_back_to_back();
        int em2 [8];
        em2 = '{100, 200, 300, 400, 50, 0, 0, 399};
        xv = '{16'sd0, 16'sd2048, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd2048};
        bus.out_ready = 1'b1;
        bus.frame_stb = 1'b1;
        tick();
        bus.frame_stb = 1'b0;
        for (int k = 0; k < 7; k++)
            tick();
        vectors++;
        if (bus.out_bin !== 3'd7 || bus.out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last: bin=%0d last=%b, required 7/1", bus.out_bin, bus.out_last);
        end
        xv = '{16'sd100, -16'sd200, 16'sd300, -16'sd400, 16'sd50, 16'sd0, 16'sd0, 16'sd399};
        bus.frame_stb = 1'b1;
        tick();
        bus.frame_stb = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_bin !== 3'd0 || bus.out_mag !== 16'd100 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: valid=%b bin=%0d mag=%0d ovr=%b, required 1/0/100/0",
                     bus.out_valid, bus.out_bin, bus.out_mag, bus.overrun);
        end
        vectors++;
        if (bus.peak_valid !== 1'b1 || bus.peak_bin !== 3'd1 || bus.peak_mag !== 16'd2048) begin
            errors++;
            $display("FAIL b2b_peak1: pv=%b pbin=%0d pmag=%0d, required 1/1/2048",
                     bus.peak_valid, bus.peak_bin, bus.peak_mag);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_bin !== 3'(k) || bus.out_mag !== 16'(em2[k])) begin
                errors++;
                $display("FAIL b2b_beat%0d: valid=%b bin=%0d mag=%0d, required 1/%0d/%0d",
                         k, bus.out_valid, bus.out_bin, bus.out_mag, k, em2[k]);
            end
            tick();
        end
        vectors++;
        if (bus.peak_valid !== 1'b1 || bus.peak_bin !== 3'd3 || bus.peak_mag !== 16'd400 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_peak2: pv=%b pbin=%0d pmag=%0d ov=%b, required 1/3/400/0",
                     bus.peak_valid, bus.peak_bin, bus.peak_mag, bus.out_valid);
        end
        tick();
        $display("back_to_back: frame 2 peak bin=%0d mag=%0d", bus.peak_bin, bus.peak_mag);
    endtask

    task automatic test_midreset();
        xv = '{16'sd0, 16'sd2048, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd2048};
        bus.out_ready = 1'b1;
        bus.frame_stb = 1'b1;
        tick();
        bus.frame_stb = 1'b0;
        for (int k = 0; k < 4; k++)
            tick();
        vectors++;
        if (bus.out_bin !== 3'd4) begin
            errors++;
            $display("FAIL mid_at_bin4: bin=%0d required 4", bus.out_bin);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.peak_valid !== 1'b0 || bus.out_bin !== 3'd0 || bus.peak_mag !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b pv=%b bin=%0d pmag=%0d, required 0/0/0/0",
                     bus.out_valid, bus.peak_valid, bus.out_bin, bus.peak_mag);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (bus.peak_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_quiet%0d: pv=%b valid=%b, required 0/0", c, bus.peak_valid, bus.out_valid);
            end
        end
        xv = '{-16'sd5, 16'sh8000, 16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd100};
        bus.frame_stb = 1'b1;
        tick();
        bus.frame_stb = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_bin !== 3'd0 || bus.out_mag !== 16'd5) begin
            errors++;
            $display("FAIL mid_restart: valid=%b bin=%0d mag=%0d, required 1/0/5",
                     bus.out_valid, bus.out_bin, bus.out_mag);
        end
        for (int k = 0; k < 8; k++)
            tick();
        vectors++;
        if (bus.peak_valid !== 1'b1 || bus.peak_bin !== 3'd1 || bus.peak_mag !== 16'd32767) begin
            errors++;
            $display("FAIL mid_peak: pv=%b pbin=%0d pmag=%0d, required 1/1/32767",
                     bus.peak_valid, bus.peak_bin, bus.peak_mag);
        end
        tick();
        $display("midreset: restart peak bin=%0d mag=%0d", bus.peak_bin, bus.peak_mag);
    endtask

    initial begin
        vectors = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.frame_stb = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            xv[i] = '0;
        #2;
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_back_to_back();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
